// File: rtl/membus_mem.sv
// rtl/membus_mem.sv - memory-bus responder: word RAM plus MMIO console FIFO, status, error capture; optional cycle counter under MEMBUS_MEM_CYCLECTR_EN
module membus_mem #(
    parameter int          MEM_WORDS = 16384,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
    parameter int          TXQ_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] busra,
    output logic [31:0] busrd,
    input  logic [31:0] buswa,
    input  logic [31:0] buswd,
    input  logic        buswe,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        bus_err
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam int          QW        = $clog2(TXQ_DEPTH);
    localparam int          PW        = QW + 1;
    localparam logic [32:0] RAM_BYTES = 33'(MEM_WORDS) * 33'd4;

    localparam logic [2:0] OFF_TXDATA  = 3'd0;
    localparam logic [2:0] OFF_STATUS  = 3'd1;
    localparam logic [2:0] OFF_CYC_LO  = 3'd2;
    localparam logic [2:0] OFF_CYC_HI  = 3'd3;
    localparam logic [2:0] OFF_ERRADDR = 3'd4;

    // ---------------------------------------------------------------
    // Address decode, read and write side
    // ---------------------------------------------------------------
    logic       rd_ram, rd_mmio;
    logic       wr_ram, wr_mmio, wr_unmapped;
    logic [2:0] rd_off, wr_off;

    // RAM takes priority should a parameterisation ever overlap the window
    always_comb begin
        rd_ram      = ({1'b0, busra} < RAM_BYTES);
        rd_mmio     = !rd_ram && (busra[31:5] == MMIO_BASE[31:5]);
        rd_off      = busra[4:2];
        wr_ram      = buswe && ({1'b0, buswa} < RAM_BYTES);
        wr_mmio     = buswe && !wr_ram && (buswa[31:5] == MMIO_BASE[31:5]);
        wr_unmapped = buswe && !wr_ram && !wr_mmio;
        wr_off      = buswa[4:2];
    end

    // ---------------------------------------------------------------
    // RAM (contents survive reset)
    // ---------------------------------------------------------------
    logic [31:0] mem_q [MEM_WORDS];

    // Commit full merged word; reset suppresses the write like all other state
    always_ff @(posedge clk) begin
        if (!rst && wr_ram) begin
            mem_q[buswa[AW+1:2]] <= buswd;
        end
    end

    // ---------------------------------------------------------------
    // Console TX FIFO
    // ---------------------------------------------------------------
    logic [7:0]    txq_q [TXQ_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] txq_count;
    logic          txq_empty, txq_full;
    logic          push_req, push_ok, pop;

    // Extra wrap bit on the pointers separates full from empty
    always_comb begin
        txq_count = wr_ptr_q - rd_ptr_q;
        txq_empty = (txq_count == '0);
        txq_full  = (txq_count == PW'(TXQ_DEPTH));
        push_req  = wr_mmio && (wr_off == OFF_TXDATA);
        pop       = !txq_empty && tx_ready;
        // a simultaneous pop frees a slot, so a full FIFO still accepts
        push_ok   = push_req && (!txq_full || pop);
        wr_ptr_d  = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    end

    // Storage is not reset; empty pointers make stale entries invisible
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            txq_q[wr_ptr_q[QW-1:0]] <= buswd[7:0];
        end
    end

    assign tx_valid = !txq_empty;
    assign tx_data  = txq_empty ? 8'h00 : txq_q[rd_ptr_q[QW-1:0]];

    // ---------------------------------------------------------------
    // Sticky flags: overflow, bus error and captured address
    // ---------------------------------------------------------------
    logic        ovf_q, ovf_d;
    logic        err_q, err_d;
    logic [31:0] erraddr_q, erraddr_d;

    // Set and clear sources live at different offsets, so they never collide
    always_comb begin
        ovf_d     = ovf_q;
        err_d     = err_q;
        erraddr_d = erraddr_q;
        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end else if (wr_mmio && (wr_off == OFF_STATUS)) begin
            ovf_d = 1'b0;
        end
        if (wr_unmapped) begin
            err_d = 1'b1;
            // only the first fault since the last clear is recorded
            if (!err_q) begin
                erraddr_d = buswa;
            end
        end else if (wr_mmio && (wr_off == OFF_ERRADDR)) begin
            err_d     = 1'b0;
            erraddr_d = '0;
        end
    end

    // Control-state registers; reset wins over any same-cycle write or pop
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
            erraddr_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
            erraddr_q <= erraddr_d;
        end
    end

    assign bus_err = err_q;

    // ---------------------------------------------------------------
    // Optional free-running cycle counter
    // ---------------------------------------------------------------
    logic [31:0] cyc_lo_rd, cyc_hi_rd;

`ifdef MEMBUS_MEM_CYCLECTR_EN
    logic [63:0] cyc_q;
    logic [31:0] cyc_hi_shadow_q;

    // Count every cycle; a LO read snapshots HI so a LO-then-HI pair never tears
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q           <= '0;
            cyc_hi_shadow_q <= '0;
        end else begin
            cyc_q <= cyc_q + 64'd1;
            if (rd_mmio && (rd_off == OFF_CYC_LO)) begin
                cyc_hi_shadow_q <= cyc_q[63:32];
            end
        end
    end

    assign cyc_lo_rd = cyc_q[31:0];
    assign cyc_hi_rd = cyc_hi_shadow_q;
`else
    assign cyc_lo_rd = 32'h0;
    assign cyc_hi_rd = 32'h0;
`endif

    // ---------------------------------------------------------------
    // Read mux: zero latency, unmapped and reserved offsets read 0
    // ---------------------------------------------------------------
    logic [31:0] status_word;

    // Status layout: overflow[8] full[7] empty[6] count[5:0]
    always_comb begin
        status_word = {23'h0, ovf_q, txq_full, txq_empty, 6'(txq_count)};
    end

    // Pre-edge state is shown, so a same-cycle write to the read word is not forwarded
    always_comb begin
        busrd = 32'h0;
        if (rd_ram) begin
            busrd = mem_q[busra[AW+1:2]];
        end else if (rd_mmio) begin
            case (rd_off)
                OFF_STATUS:  busrd = status_word;
                OFF_CYC_LO:  busrd = cyc_lo_rd;
                OFF_CYC_HI:  busrd = cyc_hi_rd;
                OFF_ERRADDR: busrd = erraddr_q;
                default:     busrd = 32'h0;
            endcase
        end
    end

endmodule
